kf_weight_update_arbiter: RTL and testbench
===========================================

# kf_weight_update_arbiter

Shares the single synaptic weight URAM port between the dream engine (fire-and-forget delta pulses during sleep) and the online plasticity/host path (valid/ready). Each accepted request is one read-modify-write: read the current weight, add the signed delta with saturation, and write the result back. The block sits between both update sources and the weight URAM inside the Kitten Fabric core.

## Interface
Parameters:
- ADDR_BITS, 16, synapse address width (matches KF_SYNAPSE_ID_BITS)
- W_BITS, 8, signed weight and delta width (matches W_WIDTH)
- RD_LAT, 2, URAM read latency in cycles, ≥1
- FIFO_DEPTH, 4, dream-port buffer depth, power of 2, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- dream_we  in  1  dream update pulse; no backpressure
- dream_addr  in  ADDR_BITS  dream target synapse
- dream_delta  in  W_BITS  signed dream delta
- onl_valid  in  1  online request valid
- onl_ready  out  1  online request accepted this cycle
- onl_addr  in  ADDR_BITS  online target synapse
- onl_delta  in  W_BITS  signed online delta
- freeze  in  1  suppresses new grants
- stat_clr  in  1  clears counters and sticky flags
- ram_rd_en  out  1  URAM read strobe
- ram_addr  out  ADDR_BITS  URAM address, shared by read and write
- ram_rd_data  in  W_BITS  URAM read data, valid RD_LAT cycles after ram_rd_en
- ram_we  out  1  URAM write strobe
- ram_wr_data  out  W_BITS  saturated new weight
- busy  out  1  FSM is not IDLE, or the FIFO is non-empty
- dream_ovf  out  1  sticky: a dream pulse was dropped
- upd_count  out  32  completed writes; wraps
- sat_count  out  16  saturated writes (see Configuration)

## Operation
- Dream port: dream_we pushes {addr, delta} into the FIFO. If the FIFO is full and no pop occurs in the same cycle, the push is dropped and dream_ovf is set. A push into a full FIFO coincident with a pop is accepted, and the occupancy stays at full.
- Arbitration happens in IDLE only, and only when freeze=0. Candidates are FIFO non-empty (port 0) and onl_valid (port 1). Arbitration is round-robin: the port not granted last wins a tie. After reset, port 0 has priority.
- onl_ready is combinational and is high only in the IDLE cycle that grants port 1. A port 0 grant pops the FIFO in that same cycle.
- FSM states:
  - IDLE: on a grant, latch addr and delta, then go to RD.
  - RD: ram_rd_en=1 and ram_addr=latched addr, for one cycle; then go to WAIT.
  - WAIT: stay for RD_LAT cycles. On the last cycle, capture ram_rd_data; then go to WR.
  - WR: ram_we=1, ram_addr=latched addr, ram_wr_data=sat(old+delta); upd_count++; then go to IDLE.
- Arithmetic: compute old+delta sign-extended to W_BITS+1 bits, then clamp to [-2^(W_BITS-1), 2^(W_BITS-1)-1].
- Only one RMW is in flight at a time, so there are no read-after-write hazards. Back-to-back updates to the same address are applied in grant order.
- freeze asserted mid-RMW: the current RMW completes and no further grants occur. FIFO pushes continue.
- stat_clr: zeroes upd_count, sat_count and dream_ovf next cycle. It takes priority over a same-cycle increment or set.
- Reset mid-RMW: the write is abandoned, the FIFO is emptied, and the FSM returns to IDLE.
- Reset values: onl_ready=0, ram_rd_en=0, ram_we=0, ram_addr=0, ram_wr_data=0, busy=0, dream_ovf=0, upd_count=0, sat_count=0, last-grant pointer=port 1 (so port 0 wins first).

## Timing
- Grant at cycle T (IDLE). ram_rd_en at T+1. Data captured at T+1+RD_LAT. ram_we at T+2+RD_LAT. IDLE again at T+3+RD_LAT, where a new grant is possible.
- Occupancy is RD_LAT+3 cycles per update (5 at the default). Peak throughput is one update per RD_LAT+3 cycles.
- Dream push-to-grant latency is at least 1 cycle: an entry pushed at cycle T is first visible to the arbiter at T+1.
- ram_rd_en and ram_we are never high in the same cycle.

## Configuration
- KF_WUA_SAT_CNT_EN defined: sat_count increments, saturating at 0xFFFF, on every WR whose result was clamped.
- KF_WUA_SAT_CNT_EN undefined: sat_count is tied to 0, and the clamp-detect logic and counter are not built. Clamping of ram_wr_data itself is always present.

## Test plan
- Single online RMW (RD_LAT=2): the URAM holds 10 at addr 0x0102; onl_delta=+5 at T. Expect onl_ready at T, ram_rd_en at T+1, ram_we at T+4 with data 15, and upd_count=1.
- Saturation: old=120, delta=+20 -> writes 127; old=-120, delta=-20 -> writes -128. With KF_WUA_SAT_CNT_EN, sat_count=2; without it, sat_count=0.
- Round-robin: the FIFO holds 3 entries and onl_valid is held high with 3 requests. Expect grants in order D,O,D,O,D,O and 6 writes.
- Overflow: 6 back-to-back dream_we pulses with FIFO_DEPTH=4 while freeze=1. Expect 2 pulses dropped and dream_ovf=1. Release freeze; expect exactly 4 writes. Then stat_clr clears dream_ovf.
- Same-address ordering: dream +3 then online -1 to addr 0x0005, which starts at 0. Expect sequential writes of 3 then 2.
- Reset mid-RMW: assert rst_n=0 during WAIT. Expect no ram_we, all outputs at their reset values, and an empty FIFO (busy=0).

Source files
------------

// File: rtl/kf_weight_update_arbiter.sv
// kf_weight_update_arbiter
// Shares the single synaptic weight URAM port between the dream engine
// (fire-and-forget pulses, buffered in a small FIFO) and the online
// plasticity/host path (valid/ready). Every granted request is one
// read-modify-write: read the weight, add the signed delta with saturation,
// and write the result back. Only one RMW is in flight at a time.
//
// Optional feature macro: KF_WUA_SAT_CNT_EN
//   defined   -> sat_count counts clamped writes (saturating at 0xFFFF)
//   undefined -> sat_count is tied to zero and the clamp counter is not built
//
// Online handshake: a request transfers on a rising edge where onl_valid and
// onl_ready are both high. onl_ready is combinational and only rises in the
// IDLE cycle that grants the online port. The requester holds onl_addr and
// onl_delta stable while onl_valid is high and onl_ready is low.
module kf_weight_update_arbiter #(
  parameter int ADDR_BITS  = 16,
  parameter int W_BITS     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dream_we,
  input  logic [ADDR_BITS-1:0] dream_addr,
  input  logic [W_BITS-1:0]    dream_delta,
  input  logic                 onl_valid,
  output logic                 onl_ready,
  input  logic [ADDR_BITS-1:0] onl_addr,
  input  logic [W_BITS-1:0]    onl_delta,
  input  logic                 freeze,
  input  logic                 stat_clr,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [W_BITS-1:0]    ram_rd_data,
  output logic                 ram_we,
  output logic [W_BITS-1:0]    ram_wr_data,
  output logic                 busy,
  output logic                 dream_ovf,
  output logic [31:0]          upd_count,
  output logic [15:0]          sat_count,
  output logic [1:0]           dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

  state_t                state;
  logic [W_BITS-1:0]     lat_delta;
  logic [CW-1:0]         wait_cnt;
  logic                  last_port;   // 1: online port was granted last

  logic [ADDR_BITS-1:0]  fifo_addr  [FIFO_DEPTH];
  logic [W_BITS-1:0]     fifo_delta [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_cnt;
  logic                  fifo_empty, fifo_full;
  logic                  push, grant_d, grant_o;

  logic [W_BITS:0]       sum;
  logic                  sum_clamped;
  logic [W_BITS-1:0]     sat_val;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  // A push into a full FIFO is still taken when the same cycle pops.
  assign push       = dream_we && (!fifo_full || grant_d);
  assign onl_ready  = grant_o;
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign dbg_state  = state;

  // Round-robin arbitration, evaluated only in IDLE while not frozen.
  always_comb begin
    grant_d = 1'b0;
    grant_o = 1'b0;
    if (state == S_IDLE && !freeze) begin
      if (!fifo_empty && onl_valid) begin
        if (last_port) grant_d = 1'b1;
        else           grant_o = 1'b1;
      end else if (!fifo_empty) begin
        grant_d = 1'b1;
      end else if (onl_valid) begin
        grant_o = 1'b1;
      end
    end
  end

  // Old weight plus delta at W_BITS+1 bits, clamped to the signed weight range.
  always_comb begin
    sum         = {ram_rd_data[W_BITS-1], ram_rd_data} + {lat_delta[W_BITS-1], lat_delta};
    sum_clamped = (sum[W_BITS] != sum[W_BITS-1]);
    if (sum_clamped)
      sat_val = sum[W_BITS] ? {1'b1, {(W_BITS-1){1'b0}}} : {1'b0, {(W_BITS-1){1'b1}}};
    else
      sat_val = sum[W_BITS-1:0];
  end

  // Dream FIFO payload storage; no reset needed, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= dream_addr;
      fifo_delta[wr_ptr] <= dream_delta;
    end
  end

  // Dream FIFO pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (grant_d) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(grant_d);
    end
  end

  // RMW sequencer: IDLE -> RD -> WAIT (RD_LAT cycles) -> WR -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_delta   <= '0;
      wait_cnt    <= '0;
      last_port   <= 1'b1;
      ram_rd_en   <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_rd_en <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_d) begin
            ram_addr  <= fifo_addr[rd_ptr];
            lat_delta <= fifo_delta[rd_ptr];
            last_port <= 1'b0;
            ram_rd_en <= 1'b1;
            state     <= S_RD;
          end else if (grant_o) begin
            ram_addr  <= onl_addr;
            lat_delta <= onl_delta;
            last_port <= 1'b1;
            ram_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end
        S_RD: begin
          wait_cnt <= CW'(RD_LAT - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            ram_wr_data <= sat_val;
            ram_we      <= 1'b1;
            state       <= S_WR;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completed-write counter and dropped-pulse flag; clear wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_count <= '0;
      dream_ovf <= 1'b0;
    end else if (stat_clr) begin
      upd_count <= '0;
      dream_ovf <= 1'b0;
    end else begin
      if (state == S_WR) upd_count <= upd_count + 32'd1;
      if (dream_we && fifo_full && !grant_d) dream_ovf <= 1'b1;
    end
  end

`ifdef KF_WUA_SAT_CNT_EN
  logic wr_clamped;

  // Remember whether the pending write was clamped, then count it in WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_clamped <= 1'b0;
      sat_count  <= '0;
    end else begin
      if (state == S_WAIT && wait_cnt == '0) wr_clamped <= sum_clamped;
      if (stat_clr)
        sat_count <= '0;
      else if (state == S_WR && wr_clamped && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_kf_weight_update_arbiter.sv
// Directed + randomized bench for kf_weight_update_arbiter (default parameters).
// A behavioural URAM with RD_LAT read latency sits on the RAM port; expected
// writes come from a per-address weight model with integer clamping.
module tb_kf_weight_update_arbiter;

  localparam int AB  = 16;
  localparam int WB  = 8;
  localparam int RDL = 2;
  localparam int FD  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          dream_we = 1'b0;
  logic [AB-1:0] dream_addr = '0;
  logic [WB-1:0] dream_delta = '0;
  logic          onl_valid = 1'b0;
  logic          onl_ready;
  logic [AB-1:0] onl_addr = '0;
  logic [WB-1:0] onl_delta = '0;
  logic          freeze = 1'b0;
  logic          stat_clr = 1'b0;
  logic          ram_rd_en;
  logic [AB-1:0] ram_addr;
  logic [WB-1:0] ram_rd_data;
  logic          ram_we;
  logic [WB-1:0] ram_wr_data;
  logic          busy;
  logic          dream_ovf;
  logic [31:0]   upd_count;
  logic [15:0]   sat_count;
  logic [1:0]    dbg_state;

  kf_weight_update_arbiter #(
    .ADDR_BITS(AB), .W_BITS(WB), .RD_LAT(RDL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dream_we(dream_we), .dream_addr(dream_addr), .dream_delta(dream_delta),
    .onl_valid(onl_valid), .onl_ready(onl_ready), .onl_addr(onl_addr), .onl_delta(onl_delta),
    .freeze(freeze), .stat_clr(stat_clr),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .ram_we(ram_we), .ram_wr_data(ram_wr_data),
    .busy(busy), .dream_ovf(dream_ovf), .upd_count(upd_count), .sat_count(sat_count),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural URAM ----------------
  logic [WB-1:0] mem [0:65535];
  logic [WB-1:0] rd_pipe [RDL];
  logic          mem_clr = 1'b0;
  logic          pl_en = 1'b0;
  logic [AB-1:0] pl_addr = '0;
  logic [WB-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= '0;
    end else begin
      if (pl_en)  mem[pl_addr]  <= pl_data;
      if (ram_we) mem[ram_addr] <= ram_wr_data;
    end
    rd_pipe[0] <= ram_rd_en ? mem[ram_addr] : 8'h00;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rd_data = rd_pipe[RDL-1];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [23:0] exp_d[$];
  logic [23:0] exp_o[$];
  logic [WB-1:0] ref_mem [0:65535];
  int upd_exp = 0;
  int sat_model = 0;
  int dream_wr_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor plus a standing check that read and write never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we === 1'b1) begin
        wr_q.push_back({ram_addr, ram_wr_data});
        if (ram_addr[15:8] == 8'h02) dream_wr_seen++;
      end
      chk("rd_we_overlap", {31'b0, ram_rd_en & ram_we}, 32'd0);
    end
  end

  // Model: saturating add on the stored weight, in plain integers.
  function automatic logic [23:0] model_upd(input logic [15:0] a, input logic [7:0] d);
    int s;
    s = int'($signed(ref_mem[a])) + int'($signed(d));
    if (s > 127) begin
      s = 127;
      sat_model++;
    end else if (s < -128) begin
      s = -128;
      sat_model++;
    end
    ref_mem[a] = s[7:0];
    upd_exp++;
    return {a, ref_mem[a]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic dream(input logic [15:0] a, input logic [7:0] d);
    dream_we = 1'b1; dream_addr = a; dream_delta = d;
    @(negedge clk);
    dream_we = 1'b0;
  endtask

  task automatic online(input logic [15:0] a, input logic [7:0] d);
    int n;
    n = 0;
    onl_valid = 1'b1; onl_addr = a; onl_delta = d;
    #1;
    while (onl_ready !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("onl_accept", {31'b0, onl_ready}, 32'd1);
    @(negedge clk);
    onl_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk); n++;
    end
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    while (exp_q.size() > 0 && wr_q.size() > 0)
      chk({tag, "_wr"}, {8'h0, wr_q.pop_front()}, {8'h0, exp_q.pop_front()});
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_upd"}, upd_count, upd_exp);
`ifdef KF_WUA_SAT_CNT_EN
    chk({tag, "_sat"}, {16'h0, sat_count}, sat_model);
`else
    chk({tag, "_sat"}, {16'h0, sat_count}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [23:0] e;
    logic [15:0] a;
    logic [7:0]  d;
    int          base_seen;
    int          pushed;
    int          n;

    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

    // Reset and clear the URAM model.
    mem_clr = 1'b1;
    tick(3);
    #1;
    chk("rst_ctrl", {26'b0, onl_ready, ram_rd_en, ram_we, busy, dream_ovf, 1'b0}, 32'd0);
    chk("rst_addr", {16'h0, ram_addr}, 32'd0);
    chk("rst_wdata", {24'h0, ram_wr_data}, 32'd0);
    chk("rst_upd", upd_count, 32'd0);
    chk("rst_sat", {16'h0, sat_count}, 32'd0);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    tick(1);

    // 1) Single online RMW with cycle-exact timing.
    preload(16'h0102, 8'd10);
    onl_valid = 1'b1; onl_addr = 16'h0102; onl_delta = 8'd5;
    #1;
    chk("t1_ready_T", {31'b0, onl_ready}, 32'd1);
    exp_q.push_back(model_upd(16'h0102, 8'd5));
    @(negedge clk);
    onl_valid = 1'b0;
    chk("t1_rd_en_T1", {31'b0, ram_rd_en}, 32'd1);
    chk("t1_addr_T1", {16'h0, ram_addr}, 32'h0102);
    @(negedge clk);
    chk("t1_quiet_T2", {30'b0, ram_rd_en, ram_we}, 32'd0);
    @(negedge clk);
    chk("t1_quiet_T3", {30'b0, ram_rd_en, ram_we}, 32'd0);
    @(negedge clk);
    chk("t1_we_T4", {31'b0, ram_we}, 32'd1);
    chk("t1_wdata_T4", {24'h0, ram_wr_data}, 32'd15);
    chk("t1_waddr_T4", {16'h0, ram_addr}, 32'h0102);
    @(negedge clk);
    chk("t1_busy_T5", {31'b0, busy}, 32'd0);
    check_stats("t1");
    check_writes("t1");

    // 2) Saturation at both ends.
    preload(16'h0010, 8'd120);
    preload(16'h0011, 8'h88);   // -120
    exp_q.push_back(model_upd(16'h0010, 8'd20));
    online(16'h0010, 8'd20);
    wait_idle("t2a");
    exp_q.push_back(model_upd(16'h0011, 8'hEC));   // -20
    online(16'h0011, 8'hEC);
    wait_idle("t2b");
    chk("t2_pos_clamp", {24'h0, ref_mem[16'h0010]}, 32'h7F);
    check_writes("t2");
    check_stats("t2");

    // 3) Round-robin: 3 queued dreams vs 3 online requests -> D,O,D,O,D,O.
    freeze = 1'b1;
    dream(16'h0020, 8'd1);
    dream(16'h0021, 8'd1);
    dream(16'h0022, 8'd1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_upd(16'h0020 + 16'(i), 8'd1));
      exp_q.push_back(model_upd(16'h0030 + 16'(i), 8'd1));
    end
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) online(16'h0030 + 16'(i), 8'd1);
    wait_idle("t3");
    check_writes("t3");
    check_stats("t3");

    // 4) Overflow: 6 pulses into a depth-4 FIFO while frozen.
    freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dream_we = 1'b1; dream_addr = 16'h0040 + 16'(i); dream_delta = 8'd2;
      @(negedge clk);
    end
    dream_we = 1'b0;
    tick(2);
    chk("t4_ovf_set", {31'b0, dream_ovf}, 32'd1);
    chk("t4_busy_frozen", {31'b0, busy}, 32'd1);
    chk("t4_no_write_frozen", wr_q.size(), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_upd(16'h0040 + 16'(i), 8'd2));
    freeze = 1'b0;
    wait_idle("t4");
    check_writes("t4");
    check_stats("t4");
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    upd_exp = 0;
    sat_model = 0;
    chk("t4_ovf_clr", {31'b0, dream_ovf}, 32'd0);
    check_stats("t4_clr");

    // 4b) Push into a full FIFO on the same cycle as a pop is kept.
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) dream(16'h0050 + 16'(i), 8'd3);
    freeze = 1'b0;
    dream(16'h0054, 8'd3);
    for (int i = 0; i < 5; i++) exp_q.push_back(model_upd(16'h0050 + 16'(i), 8'd3));
    wait_idle("t4b");
    chk("t4b_no_ovf", {31'b0, dream_ovf}, 32'd0);
    check_writes("t4b");
    check_stats("t4b");

    // 5) Same-address ordering.
    preload(16'h0005, 8'd0);
    exp_q.push_back(model_upd(16'h0005, 8'd3));
    exp_q.push_back(model_upd(16'h0005, 8'hFF));
    dream(16'h0005, 8'd3);
    tick(1);
    online(16'h0005, 8'hFF);
    wait_idle("t5");
    check_writes("t5");
    check_stats("t5");

    // 6) Random mix: dreams to 0x02xx, online to 0x03xx.
    base_seen = dream_wr_seen;
    pushed = 0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        a = 16'h0200 + 16'($urandom_range(0, 7));
        n = 0;
        while ((pushed - (dream_wr_seen - base_seen)) >= 3 && n < 100) begin
          @(negedge clk); n++;
        end
        exp_d.push_back(model_upd(a, d));
        dream(a, d);
        pushed++;
      end else begin
        a = 16'h0300 + 16'($urandom_range(0, 7));
        exp_o.push_back(model_upd(a, d));
        online(a, d);
      end
      tick($urandom_range(0, 4));
    end
    wait_idle("t6");
    chk("t6_nwr", wr_q.size(), exp_d.size() + exp_o.size());
    while (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      if (e[23:16] == 8'h02) begin
        if (exp_d.size() > 0) chk("t6_dream_wr", {8'h0, e}, {8'h0, exp_d.pop_front()});
      end else begin
        if (exp_o.size() > 0) chk("t6_onl_wr", {8'h0, e}, {8'h0, exp_o.pop_front()});
      end
    end
    chk("t6_dream_left", exp_d.size(), 32'd0);
    chk("t6_onl_left", exp_o.size(), 32'd0);
    chk("t6_no_ovf", {31'b0, dream_ovf}, 32'd0);
    check_stats("t6");

    // 7) Reset during WAIT abandons the write and empties the FIFO.
    freeze = 1'b1;
    dream(16'h0060, 8'd1);
    dream(16'h0061, 8'd1);
    freeze = 1'b0;
    n = 0;
    while (ram_rd_en !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t7_rd_seen", {31'b0, ram_rd_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_ctrl", {27'b0, onl_ready, ram_rd_en, ram_we, busy, dream_ovf}, 32'd0);
    chk("t7_addr", {16'h0, ram_addr}, 32'd0);
    chk("t7_wdata", {24'h0, ram_wr_data}, 32'd0);
    chk("t7_upd", upd_count, 32'd0);
    chk("t7_sat", {16'h0, sat_count}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("t7_no_write", wr_q.size(), 32'd0);
    chk("t7_busy", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
